// File: rtl/fb_fill_engine.sv
// Rectangle-fill / buffer-swap initiator for the 128x96 framebuffer's 6502-style write port.
// First strobe one cycle after acceptance, then one strobe per 1+GAP cycles; CMD_READY only when idle.
module fb_fill_engine #(
  parameter int unsigned FB_WIDTH     = 128,
  parameter int unsigned FB_HEIGHT    = 96,
  parameter int unsigned BASE_ADDR    = 4096,
  parameter int unsigned GAP          = 1,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_OP,
  input  logic [6:0]  CMD_X,
  input  logic [6:0]  CMD_Y,
  input  logic [7:0]  CMD_W,
  input  logic [6:0]  CMD_H,
  input  logic [2:0]  CMD_COLOR,
  input  logic        CMD_VSYNC_WAIT,
  input  logic        VGA_VSYNC,
  output logic        BUS_CE_N,
  output logic        BUS_RW,
  output logic [14:0] BUS_ADDR,
  output logic [6:0]  BUS_DATA,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP, S_WAIT_VS} state_t;

  localparam logic [7:0]  WIDTH8     = 8'(FB_WIDTH);
  localparam logic [7:0]  HEIGHT8    = 8'(FB_HEIGHT);
  localparam logic [14:0] BASE15     = 15'(BASE_ADDR);
  localparam logic [3:0]  GAP_LOAD   = 4'(GAP - 1);
  localparam logic [6:0]  SWAP_DATA  = 7'b1000000;

  state_t      state, state_nxt;
  logic [7:0]  x, y, x_nxt, y_nxt;
  logic [7:0]  x_start, x_end, y_end;
  logic        op_swap;
  logic [3:0]  gap_cnt, gap_nxt;
  logic [14:0] addr_nxt;
  logic [6:0]  data_nxt;
  logic        done_nxt;
  logic        accept;
  logic        vs_meta, vs_sync;
  logic [7:0]  cmd_xe_raw, cmd_ye_raw, cmd_xe, cmd_ye;
  logic [7:0]  x_inc, y_inc;

  function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [7:0] py);
    return BASE15 + 15'(py) * 15'(FB_WIDTH) + 15'(px);
  endfunction

  // 8-bit sums cannot wrap: 127+128 and 127+96 both fit.
  assign cmd_xe_raw = {1'b0, CMD_X} + CMD_W;
  assign cmd_ye_raw = {1'b0, CMD_Y} + {1'b0, CMD_H};
  assign cmd_xe     = (cmd_xe_raw > WIDTH8)  ? WIDTH8  : cmd_xe_raw;
  assign cmd_ye     = (cmd_ye_raw > HEIGHT8) ? HEIGHT8 : cmd_ye_raw;
  assign x_inc      = x + 8'd1;
  assign y_inc      = y + 8'd1;
  assign accept     = (state == S_IDLE) && CMD_VALID;

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    gap_nxt   = gap_cnt;
    addr_nxt  = BUS_ADDR;
    data_nxt  = BUS_DATA;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (CMD_VALID) begin
          x_nxt = {1'b0, CMD_X};
          y_nxt = {1'b0, CMD_Y};
          if (CMD_OP) begin
            if (!CMD_VSYNC_WAIT || vs_sync == VSYNC_ACTIVE) begin
              state_nxt = S_STROBE;
              addr_nxt  = BASE15;
              data_nxt  = SWAP_DATA;
            end else begin
              state_nxt = S_WAIT_VS;
            end
          end else if (cmd_xe <= {1'b0, CMD_X} || cmd_ye <= {1'b0, CMD_Y}) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = S_STROBE;
            addr_nxt  = pix_addr({1'b0, CMD_X}, {1'b0, CMD_Y});
            data_nxt  = {4'b0000, CMD_COLOR};
          end
        end
      end
      S_WAIT_VS: begin
        if (vs_sync == VSYNC_ACTIVE) begin
          state_nxt = S_STROBE;
          addr_nxt  = BASE15;
          data_nxt  = SWAP_DATA;
        end
      end
      S_STROBE: begin
        state_nxt = S_GAP;
        gap_nxt   = GAP_LOAD;
      end
      S_GAP: begin
        if (gap_cnt != 4'd0) begin
          gap_nxt = gap_cnt - 4'd1;
        end else if (op_swap) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else if (x_inc < x_end) begin
          state_nxt = S_STROBE;
          x_nxt     = x_inc;
          addr_nxt  = pix_addr(x_inc, y);
        end else if (y_inc < y_end) begin
          state_nxt = S_STROBE;
          x_nxt     = x_start;
          y_nxt     = y_inc;
          addr_nxt  = pix_addr(x_start, y_inc);
        end else begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
    end else begin
      vs_meta <= VGA_VSYNC;
      vs_sync <= vs_meta;
    end
  end

  // Bus and status outputs are registered from the next state so they lead the FSM by nothing.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      x         <= 8'd0;
      y         <= 8'd0;
      x_start   <= 8'd0;
      x_end     <= 8'd0;
      y_end     <= 8'd0;
      op_swap   <= 1'b0;
      gap_cnt   <= 4'd0;
      BUS_CE_N  <= 1'b1;
      BUS_RW    <= 1'b1;
      BUS_ADDR  <= 15'd0;
      BUS_DATA  <= 7'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      CMD_READY <= 1'b1;
    end else begin
      state     <= state_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      gap_cnt   <= gap_nxt;
      BUS_CE_N  <= (state_nxt != S_STROBE);
      BUS_RW    <= (state_nxt != S_STROBE);
      BUS_ADDR  <= addr_nxt;
      BUS_DATA  <= data_nxt;
      BUSY      <= (state_nxt != S_IDLE);
      DONE      <= done_nxt;
      CMD_READY <= (state_nxt == S_IDLE);
      if (accept) begin
        x_start <= {1'b0, CMD_X};
        x_end   <= cmd_xe;
        y_end   <= cmd_ye;
        op_swap <= CMD_OP;
      end
    end
  end

endmodule

// File: tb/tb_fb_fill_engine.sv
// Directed bench for fb_fill_engine: vector table plus hand sequences for vsync wait, full screen and reset.
module tb_fb_fill_engine;

  logic        CLK, RESET_N, CMD_VALID, CMD_READY, CMD_OP, CMD_VSYNC_WAIT, VGA_VSYNC;
  logic [6:0]  CMD_X, CMD_Y, CMD_H;
  logic [7:0]  CMD_W;
  logic [2:0]  CMD_COLOR;
  logic        BUS_CE_N, BUS_RW, BUSY, DONE;
  logic [14:0] BUS_ADDR;
  logic [6:0]  BUS_DATA;

  fb_fill_engine dut (
    .CLK(CLK), .RESET_N(RESET_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_X(CMD_X), .CMD_Y(CMD_Y), .CMD_W(CMD_W), .CMD_H(CMD_H),
    .CMD_COLOR(CMD_COLOR), .CMD_VSYNC_WAIT(CMD_VSYNC_WAIT), .VGA_VSYNC(VGA_VSYNC),
    .BUS_CE_N(BUS_CE_N), .BUS_RW(BUS_RW), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
    .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int failures = 0;

  // Results of the most recent monitored command.
  int st_cyc[$];
  int st_addr[$];
  int st_data[$];
  int done_cyc, adj_err, busy_err, rw_err, rdy_err;

  typedef struct {
    int op, x, y, w, h, color, vw;
    int n, a_first, a_last, data, done;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic accept(input int op, input int x, input int y, input int w, input int h,
                        input int color, input int vw);
    @(negedge CLK);
    chk("ready_before_cmd", int'(CMD_READY), 1);
    CMD_OP = op[0]; CMD_X = x[6:0]; CMD_Y = y[6:0]; CMD_W = w[7:0]; CMD_H = h[6:0];
    CMD_COLOR = color[2:0]; CMD_VSYNC_WAIT = vw[0];
    CMD_VALID = 1'b1;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
  endtask

  // Cycle k is the clock period following acceptance edge N+k-1.
  task automatic monitor(input int budget, input int vs_drop, input int pulse_k);
    logic prev_st;
    st_cyc.delete(); st_addr.delete(); st_data.delete();
    done_cyc = -1; adj_err = 0; busy_err = 0; rw_err = 0; rdy_err = 0;
    prev_st = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge CLK);
      if (BUS_RW != BUS_CE_N) rw_err++;
      if (!BUS_CE_N) begin
        if (prev_st) adj_err++;
        st_cyc.push_back(k);
        st_addr.push_back(int'(BUS_ADDR));
        st_data.push_back(int'(BUS_DATA));
      end
      prev_st = !BUS_CE_N;
      if (k == vs_drop) VGA_VSYNC = 1'b0;
      if (k == pulse_k) begin
        CMD_VALID = 1'b1; CMD_OP = 1'b1; CMD_X = 7'd50; CMD_Y = 7'd3; CMD_W = 8'd1; CMD_H = 7'd1;
      end
      if (k == pulse_k + 1) CMD_VALID = 1'b0;
      if (DONE) begin
        done_cyc = k;
        break;
      end
      if (!BUSY) busy_err++;
      if (CMD_READY) rdy_err++;
    end
  endtask

  function automatic int q_at(input int idx, input int which);
    if (which == 0) return (idx < st_cyc.size()) ? st_cyc[idx] : -1;
    if (which == 1) return (idx < st_addr.size()) ? st_addr[idx] : -1;
    return (idx < st_data.size()) ? st_data[idx] : -1;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c[4];
    int exp_a[4];
    int done_seen, ce_low;

    //             op  x   y    w    h  c  vw   n   first  last  data done
    vecs[0] = '{0,   0,  0,   2,   2, 5, 0,   4,  4096,  4225,  5,  9};
    vecs[1] = '{0, 126, 95,  10,   5, 3, 0,   2, 16382, 16383,  3,  5};
    vecs[2] = '{0,  10, 10,   0,   3, 6, 0,   0,     0,     0,  0,  1};
    vecs[3] = '{0,  10,100,   4,   4, 6, 0,   0,     0,     0,  0,  1};
    vecs[4] = '{0,  10, 10,   4,   0, 6, 0,   0,     0,     0,  0,  1};
    vecs[5] = '{1,   0,  0,   0,   0, 0, 0,   1,  4096,  4096, 64,  3};
    vecs[6] = '{0,   5,  7,   3,   1, 7, 0,   3,  4997,  4999,  7,  7};
    vecs[7] = '{0, 127,  0, 128,   2, 2, 0,   2,  4223,  4351,  2,  5};
    vecs[8] = '{0, 120, 94,   8,   2, 1, 0,  16, 16248, 16383,  1, 33};
    vecs[9] = '{1,   3,  3,   3,   3, 7, 1,   1,  4096,  4096, 64,  3};

    RESET_N = 1'b0; CMD_VALID = 1'b0; CMD_OP = 1'b0; CMD_X = '0; CMD_Y = '0; CMD_W = '0;
    CMD_H = '0; CMD_COLOR = '0; CMD_VSYNC_WAIT = 1'b0; VGA_VSYNC = 1'b0;
    #12;
    chk("rst_ready", int'(CMD_READY), 1);
    chk("rst_ce_n", int'(BUS_CE_N), 1);
    chk("rst_rw", int'(BUS_RW), 1);
    chk("rst_addr", int'(BUS_ADDR), 0);
    chk("rst_data", int'(BUS_DATA), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    foreach (vecs[i]) begin
      accept(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color, vecs[i].vw);
      monitor(200, 0, 0);
      chk($sformatf("v%0d_strobes", i), st_cyc.size(), vecs[i].n);
      chk($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].done);
      chk($sformatf("v%0d_busy", i), busy_err, 0);
      chk($sformatf("v%0d_adjacent", i), adj_err, 0);
      chk($sformatf("v%0d_rw", i), rw_err, 0);
      if (vecs[i].n > 0) begin
        chk($sformatf("v%0d_first_addr", i), q_at(0, 1), vecs[i].a_first);
        chk($sformatf("v%0d_last_addr", i), q_at(st_addr.size() - 1, 1), vecs[i].a_last);
        chk($sformatf("v%0d_data", i), q_at(0, 2), vecs[i].data);
      end
      if (i == 0) begin
        exp_c = '{1, 3, 5, 7};
        exp_a = '{4096, 4097, 4224, 4225};
        for (int j = 0; j < 4; j++) begin
          chk($sformatf("fill2x2_cycle%0d", j), q_at(j, 0), exp_c[j]);
          chk($sformatf("fill2x2_addr%0d", j), q_at(j, 1), exp_a[j]);
        end
      end
    end

    // Swap waiting for vsync: inactive level first, drop to active in cycle 20.
    VGA_VSYNC = 1'b1;
    repeat (4) @(negedge CLK);
    accept(1, 0, 0, 0, 0, 0, 1);
    monitor(60, 20, 0);
    chk("vswap_strobes", st_cyc.size(), 1);
    chk("vswap_cycle", q_at(0, 0), 23);
    chk("vswap_addr", q_at(0, 1), 4096);
    chk("vswap_data", q_at(0, 2), 64);
    chk("vswap_done", done_cyc, 25);

    // Full screen with an ignored command pulse partway through.
    accept(0, 0, 0, 128, 96, 4, 0);
    monitor(30000, 0, 100);
    chk("full_strobes", st_cyc.size(), 12288);
    chk("full_first_addr", q_at(0, 1), 4096);
    chk("full_last_addr", q_at(st_addr.size() - 1, 1), 16383);
    chk("full_last_cycle", q_at(st_cyc.size() - 1, 0), 24575);
    chk("full_done", done_cyc, 24577);
    chk("full_adjacent", adj_err, 0);
    chk("full_busy", busy_err, 0);
    chk("full_ready_low", rdy_err, 0);
    chk("full_data", q_at(5000, 2), 4);

    // Reset asserted for part of a strobe cycle.
    accept(0, 0, 0, 128, 96, 2, 0);
    for (int k = 1; k <= 51; k++) @(negedge CLK);
    chk("mid_ce_before_rst", int'(BUS_CE_N), 0);
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_ce_in_rst", int'(BUS_CE_N), 1);
    chk("mid_rw_in_rst", int'(BUS_RW), 1);
    chk("mid_busy_in_rst", int'(BUSY), 0);
    #1 RESET_N = 1'b1;
    done_seen = 0;
    ce_low = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (DONE) done_seen++;
      if (!BUS_CE_N) ce_low++;
    end
    chk("post_rst_done", done_seen, 0);
    chk("post_rst_strobes", ce_low, 0);
    chk("post_rst_addr", int'(BUS_ADDR), 0);
    chk("post_rst_data", int'(BUS_DATA), 0);
    chk("post_rst_busy", int'(BUSY), 0);

    accept(vecs[6].op, vecs[6].x, vecs[6].y, vecs[6].w, vecs[6].h, vecs[6].color, 0);
    monitor(100, 0, 0);
    chk("post_rst_fill_strobes", st_cyc.size(), 3);
    chk("post_rst_fill_addr", q_at(1, 1), 4998);
    chk("post_rst_fill_done", done_cyc, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_fill_engine.md
# fb_fill_engine

Hardware rectangle-fill and buffer-swap engine that acts as bus initiator toward the double-buffered 128x96 3-bit framebuffer's 6502-style write port (CE/RW/ADDR/DATA). It accepts one command at a time over a valid/ready handshake and turns it into a paced stream of single-pixel writes or one swap write. It sits between the CPU glue logic (or a sprite sequencer) and the framebuffer, freeing the CPU from 12,288 individual stores per full-screen clear.

## Interface
- FB_WIDTH, 128, framebuffer columns; the row stride.
- FB_HEIGHT, 96, framebuffer rows.
- BASE_ADDR, 4096, bus address of pixel (0,0).
- GAP, 1, idle cycles after each write strobe (legal range 1..15; the framebuffer drops back-to-back strobes).
- VSYNC_ACTIVE, 0, active level of the VGA vertical sync.
- CLK  in  1  single clock; also drives the framebuffer's CPU-side clock.
- RESET_N  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  engine idle, command accepted when VALID&READY at a rising edge.
- CMD_OP  in  1  0 = fill rectangle, 1 = buffer swap.
- CMD_X  in  7  left column, 0..127.
- CMD_Y  in  7  top row.
- CMD_W  in  8  width in pixels, 0..128.
- CMD_H  in  7  height in rows, 0..96.
- CMD_COLOR  in  3  {B,G,R} fill colour.
- CMD_VSYNC_WAIT  in  1  swap only: hold the swap until vertical sync is active.
- VGA_VSYNC  in  1  asynchronous sync from the VGA timing block.
- BUS_CE_N  out  1  write strobe, active low.
- BUS_RW  out  1  always 1 except 0 during a strobe.
- BUS_ADDR  out  15  write address.
- BUS_DATA  out  7  write data.
- BUSY  out  1  high from acceptance until DONE.
- DONE  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, STROBE, GAP, WAIT_VS.
- IDLE: CMD_READY=1. On acceptance, latch all CMD_* fields and compute the clipped extent.
  - x_end = min(X+W, FB_WIDTH).
  - y_end = min(Y+H, FB_HEIGHT).
  - Use 8-bit arithmetic; there is no wrap-around.
- Fill:
  - If x_end<=X or y_end<=Y (W=0, H=0, Y>=96), go directly to the DONE pulse with zero strobes.
  - Otherwise scan row-major, x inner, starting at (X,Y).
- Swap:
  - If CMD_VSYNC_WAIT=1, go to WAIT_VS until the synchronized vsync equals VSYNC_ACTIVE, then STROBE.
  - Otherwise go directly to STROBE.
- STROBE (1 cycle):
  - BUS_CE_N=0, BUS_RW=0.
  - Fill: BUS_ADDR = BASE_ADDR + y*FB_WIDTH + x, BUS_DATA = {4'b0000, COLOR}.
  - Swap: BUS_ADDR = BASE_ADDR, BUS_DATA = 7'b1000000.
- GAP (GAP cycles):
  - BUS_CE_N=1, BUS_RW=1; ADDR and DATA hold their last values.
  - At the end, advance x. When x reaches x_end, reset x to X and increment y.
  - When y reaches y_end (or after a swap), pulse DONE and return to IDLE.
- VGA_VSYNC passes through a 2-flop synchronizer before use.
- Reset values: CMD_READY=1, BUS_CE_N=1, BUS_RW=1, BUS_ADDR=0, BUS_DATA=0, BUSY=0, DONE=0, state IDLE, synchronizer flops 0.
- Reset mid-command: the bus goes idle immediately (asynchronously) and the command is abandoned with no DONE pulse.
- CMD_* inputs are ignored while BUSY.

## Timing
- All outputs are registered and change only on the rising edge of CLK. They are therefore stable at the framebuffer's falling-edge sample.
- Acceptance edge N: BUSY=1 and CMD_READY=0 from N+1. The first strobe appears in cycle N+1.
- Per-pixel period = 1+GAP cycles. A fill of P pixels has its last strobe at N+1+(P-1)(1+GAP).
- DONE is high in the final GAP cycle's successor, i.e. cycle N+1+P(1+GAP). CMD_READY=1 in the same cycle, so a new command can be accepted at that edge.
- Zero-pixel fill: DONE at cycle N+1, with no strobe.
- Swap with wait: strobe occurs 3 cycles after VGA_VSYNC reaches the active level (2 sync + 1 registered). If vsync is already active, the strobe occurs at N+1 at the earliest.
- Strobes are never adjacent; at least GAP deasserted cycles separate them.

## Test plan
- Reset, then fill X=0 Y=0 W=2 H=2 COLOR=3'b101, GAP=1:
  - Strobes at cycles 1,3,5,7 with addresses 4096, 4097, 4224, 4225, all with DATA=0x05.
  - DONE at cycle 9.
- Fill X=126 Y=95 W=10 H=5: clipped to exactly 2 strobes at 4096+95*128+126=16382 and 16383, then DONE.
- Fill with W=0, and separately Y=100: no strobe; DONE exactly one cycle after acceptance.
- Swap with CMD_VSYNC_WAIT=1 while VGA_VSYNC=1, drop VGA_VSYNC to 0 at cycle 20: BUS_CE_N stays high until a single strobe at cycle 23 with ADDR=4096, DATA=0x40.
- Full-screen fill 0,0,128,96: 12,288 strobes, no two adjacent, last address 16383, BUSY high throughout; CMD_VALID pulses mid-fill are ignored.
- Assert RESET_N low mid-fill for a partial cycle: BUS_CE_N=1 immediately; after release, outputs are at reset values, there is no DONE, and CMD_READY=1.
